// File: rtl/mem_responder.sv
// Main-memory responder on the cache-to-memory line bus (bus 2): accepts line reads/writes and answers after MEM_DELAY.
// Define MEM_PATTERN_INIT_EN so that never-written bytes read back as addr[7:0] ^ addr[15:8].
module mem_responder #(
   parameter int ADDR2_W    = 15,
   parameter int LINE_BYTES = 16,
   parameter int DATA_W     = 16,
   parameter int MEM_DELAY  = 100
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   inout  wire logic [ADDR2_W-1:0] A2_WIRE,
   inout  wire logic [DATA_W-1:0]  D2_WIRE,
   inout  wire logic [1:0]         C2_WIRE
);

   localparam int BEATS   = LINE_BYTES / 2;
   localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WORD_AW = ADDR2_W + BEAT_W;
   localparam int DLY_W   = $clog2(MEM_DELAY);

   localparam logic [BEAT_W-1:0] BEAT_LAST     = BEAT_W'(BEATS - 1);
   localparam logic [DLY_W-1:0]  DLY_INIT      = DLY_W'(MEM_DELAY - 2);
   localparam logic [1:0]        C2_RESPONSE   = 2'b01;
   localparam logic [1:0]        C2_READ_LINE  = 2'b10;
   localparam logic [1:0]        C2_WRITE_LINE = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_RX   = 3'd1,
      WAIT    = 3'd2,
      RESP_WR = 3'd3,
      RESP_RD = 3'd4
   } state_t;

   state_t              state_r;
   logic [ADDR2_W-1:0]  line_r;
   logic [BEAT_W-1:0]   beat_r;
   logic [DLY_W-1:0]    dly_r;
   logic                is_wr_r;
   logic                c2_oe_r;
   logic                d2_oe_r;
   logic [DATA_W-1:0]   d2_r;

   logic [DATA_W-1:0]   mem [0:(1 << WORD_AW) - 1];

   logic                wr_en_s;
   logic [WORD_AW-1:0]  wr_idx_s;
   logic [WORD_AW-1:0]  rd_idx_s;
   logic [BEAT_W-1:0]   rd_beat_s;
   logic [DATA_W-1:0]   wr_mask_s;
   logic [DATA_W-1:0]   rd_mask_s;
   logic [DATA_W-1:0]   rd_word_s;

`ifdef MEM_PATTERN_INIT_EN
   // Words are stored XORed with the init pattern, so a zero power-up image reads back as the pattern.
   function automatic logic [DATA_W-1:0] init_word(input logic [WORD_AW-1:0] widx);
      logic [31:0] a0;
      logic [31:0] a1;
      a0 = 32'({widx, 1'b0});
      a1 = 32'({widx, 1'b1});
      return DATA_W'({a1[7:0] ^ a1[15:8], a0[7:0] ^ a0[15:8]});
   endfunction

   assign wr_mask_s = init_word(wr_idx_s);
   assign rd_mask_s = init_word(rd_idx_s);
`else
   assign wr_mask_s = {DATA_W{1'b0}};
   assign rd_mask_s = {DATA_W{1'b0}};
`endif

   assign rd_word_s = mem[rd_idx_s] ^ rd_mask_s;

   assign A2_WIRE = {ADDR2_W{1'bz}};
   assign C2_WIRE = c2_oe_r ? C2_RESPONSE : 2'bzz;
   assign D2_WIRE = d2_oe_r ? d2_r : {DATA_W{1'bz}};

   // Array write port and read-beat address selection.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_idx_s  = {line_r, beat_r};
      rd_beat_s = BEAT_W'(0);
      case (state_r)
         IDLE: begin
            if (C2_WIRE == C2_WRITE_LINE) begin
               wr_en_s  = 1'b1;
               wr_idx_s = {A2_WIRE, BEAT_W'(0)};
            end else begin
               wr_en_s  = 1'b0;
            end
         end
         WR_RX: begin
            wr_en_s = 1'b1;
         end
         RESP_RD: begin
            rd_beat_s = beat_r + BEAT_W'(1);
         end
         default: begin
            wr_en_s = 1'b0;
         end
      endcase
      rd_idx_s = {line_r, rd_beat_s};
   end

   // Line storage; contents survive reset.
   always_ff @(posedge CLK) begin
      if (wr_en_s) begin
         mem[wr_idx_s] <= D2_WIRE ^ wr_mask_s;
      end
   end

   // Protocol FSM with registered bus drive enables.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r <= IDLE;
         line_r  <= {ADDR2_W{1'b0}};
         beat_r  <= BEAT_W'(0);
         dly_r   <= DLY_W'(0);
         is_wr_r <= 1'b0;
         c2_oe_r <= 1'b0;
         d2_oe_r <= 1'b0;
         d2_r    <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               c2_oe_r <= 1'b0;
               d2_oe_r <= 1'b0;
               if (C2_WIRE == C2_READ_LINE) begin
                  line_r  <= A2_WIRE;
                  is_wr_r <= 1'b0;
                  dly_r   <= DLY_INIT;
                  state_r <= WAIT;
               end else if (C2_WIRE == C2_WRITE_LINE) begin
                  line_r  <= A2_WIRE;
                  is_wr_r <= 1'b1;
                  dly_r   <= DLY_INIT;
                  beat_r  <= BEAT_W'(1);
                  state_r <= WR_RX;
               end else begin
                  state_r <= IDLE;
               end
            end
            WR_RX: begin
               // The delay keeps running during the burst: the response is timed from the command edge.
               dly_r <= dly_r - DLY_W'(1);
               if (beat_r == BEAT_LAST) begin
                  state_r <= WAIT;
               end else begin
                  beat_r <= beat_r + BEAT_W'(1);
               end
            end
            WAIT: begin
               if (dly_r == DLY_W'(0)) begin
                  c2_oe_r <= 1'b1;
                  if (is_wr_r) begin
                     state_r <= RESP_WR;
                  end else begin
                     d2_oe_r <= 1'b1;
                     d2_r    <= rd_word_s;
                     beat_r  <= BEAT_W'(0);
                     state_r <= RESP_RD;
                  end
               end else begin
                  dly_r <= dly_r - DLY_W'(1);
               end
            end
            RESP_WR: begin
               c2_oe_r <= 1'b0;
               state_r <= IDLE;
            end
            RESP_RD: begin
               if (beat_r == BEAT_LAST) begin
                  c2_oe_r <= 1'b0;
                  d2_oe_r <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  beat_r <= beat_r + BEAT_W'(1);
                  d2_r   <= rd_word_s;
               end
            end
            default: begin
               c2_oe_r <= 1'b0;
               d2_oe_r <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed protocol scenarios plus random line traffic against a byte-level model.
module tb_mem_responder;

   localparam int ADDR2_W    = 15;
   localparam int LINE_BYTES = 16;
   localparam int DATA_W     = 16;
   localparam int MEM_DELAY  = 100;
   localparam int BEATS      = LINE_BYTES / 2;

   logic                CLK = 1'b0;
   logic                RESET_N;
   logic                tb_c2_oe, tb_a2_oe, tb_d2_oe;
   logic [1:0]          tb_c2;
   logic [ADDR2_W-1:0]  tb_a2;
   logic [DATA_W-1:0]   tb_d2;
   wire  [1:0]          c2_bus;
   wire  [ADDR2_W-1:0]  a2_bus;
   wire  [DATA_W-1:0]   d2_bus;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  ref_mem [int];
   logic [15:0] wbeats [BEATS];

   assign c2_bus = tb_c2_oe ? tb_c2 : 2'bzz;
   assign a2_bus = tb_a2_oe ? tb_a2 : {ADDR2_W{1'bz}};
   assign d2_bus = tb_d2_oe ? tb_d2 : {DATA_W{1'bz}};

   always #5 CLK = ~CLK;

   mem_responder #(
      .ADDR2_W(ADDR2_W), .LINE_BYTES(LINE_BYTES), .DATA_W(DATA_W), .MEM_DELAY(MEM_DELAY)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .A2_WIRE(a2_bus), .D2_WIRE(d2_bus), .C2_WIRE(c2_bus)
   );

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // A line counts as released when no bit is actively driven to 1 or X.
   function automatic bit released(input logic [15:0] v);
      for (int i = 0; i < 16; i++) begin
         if (v[i] === 1'b1 || v[i] === 1'bx) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic void model_beat(input logic [ADDR2_W-1:0] line, input int i,
                                      output logic [15:0] val, output bit known);
      int ab;
      logic [7:0] byt;
      known = 1'b1;
      val   = 16'h0000;
      for (int b = 0; b < 2; b++) begin
         ab = int'(line) * LINE_BYTES + 2 * i + b;
         if (ref_mem.exists(ab)) begin
            byt = ref_mem[ab];
         end else begin
`ifdef MEM_PATTERN_INIT_EN
            byt = 8'((ab & 255) ^ ((ab >> 8) & 255));
`else
            byt   = 8'h00;
            known = 1'b0;
`endif
         end
         val[8*b +: 8] = byt;
      end
   endfunction

   task automatic model_write(input logic [ADDR2_W-1:0] line, input int nbeats);
      int a;
      for (int i = 0; i < nbeats; i++) begin
         a = int'(line) * LINE_BYTES + 2 * i;
         ref_mem[a]     = wbeats[i][7:0];
         ref_mem[a + 1] = wbeats[i][15:8];
      end
   endtask

   task automatic release_all();
      tb_c2_oe = 1'b0;
      tb_a2_oe = 1'b0;
      tb_d2_oe = 1'b0;
   endtask

   // Presents a command for one cycle; returns exactly at the edge that samples it.
   task automatic issue(input logic [1:0] cmd, input logic [ADDR2_W-1:0] line, input logic [15:0] d0);
      @(posedge CLK);
      #2;
      tb_c2_oe = 1'b1; tb_c2 = cmd;
      tb_a2_oe = 1'b1; tb_a2 = line;
      tb_d2_oe = (cmd == 2'b11); tb_d2 = d0;
      @(posedge CLK);
   endtask

   // Observes n cycles after a command edge; mode 0 = no response, 1 = write response, 2 = read burst.
   task automatic watch(input string tag, input logic [ADDR2_W-1:0] line, input int mode, input int n);
      logic [15:0] eb [BEATS];
      bit          ek [BEATS];
      bit          in_win;
      for (int i = 0; i < BEATS; i++) model_beat(line, i, eb[i], ek[i]);
      for (int j = 1; j <= n; j++) begin
         @(negedge CLK);
         in_win = (mode == 2) ? (j >= MEM_DELAY && j < MEM_DELAY + BEATS)
                : (mode == 1) ? (j == MEM_DELAY) : 1'b0;
         check_value({tag, " c2"}, 32'(c2_bus === 2'b01), 32'(in_win));
         if (mode == 2 && in_win) begin
            if (ek[j - MEM_DELAY]) check_value({tag, " d2"}, 32'(d2_bus), 32'(eb[j - MEM_DELAY]));
         end else if (!tb_d2_oe) begin
            check_value({tag, " d2 rel"}, 32'(released(d2_bus)), 32'd1);
         end
      end
   endtask

   task automatic do_read(input string tag, input logic [ADDR2_W-1:0] line, input int n);
      issue(2'b10, line, 16'h0000);
      #2;
      release_all();
      watch(tag, line, 2, n);
   endtask

   task automatic do_write(input string tag, input logic [ADDR2_W-1:0] line, input int n);
      model_write(line, BEATS);
      issue(2'b11, line, wbeats[0]);
      fork
         begin
            for (int i = 1; i < BEATS; i++) begin
               #2;
               tb_c2 = 2'b00;
               tb_d2 = wbeats[i];
               @(posedge CLK);
            end
            #2;
            release_all();
         end
         watch(tag, line, 1, n);
      join
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET_N = 1'b0;
      release_all();
      tb_c2 = 2'b00; tb_a2 = '0; tb_d2 = 16'h0000;
      #1;
      check_value("reset c2", 32'(released({14'd0, c2_bus})), 32'd1);
      check_value("reset d2", 32'(released(d2_bus)), 32'd1);
      repeat (3) @(posedge CLK);
      #2 RESET_N = 1'b1;

      // Never-written line: pattern data when initialised, timing only otherwise.
      do_read("pattern rd", 15'h0001, MEM_DELAY + BEATS + 1);

      // Write then read back at the earliest legal edges.
      for (int i = 0; i < BEATS; i++) wbeats[i] = {8'(2 * i + 1), 8'(2 * i)};
      do_write("wr 1234", 15'h1234, MEM_DELAY);
      do_read("rd 1234", 15'h1234, MEM_DELAY + BEATS - 1);
      do_read("rd 1234 b2b", 15'h1234, MEM_DELAY + BEATS + 1);

      // A write issued while a read is pending must be ignored.
      for (int i = 0; i < BEATS; i++) wbeats[i] = 16'($urandom);
      do_write("pre 0002", 15'h0002, MEM_DELAY + 1);
      fork
         do_read("busy rd", 15'h0002, MEM_DELAY + BEATS + 1);
         begin
            repeat (2) @(posedge CLK);
            repeat (49) @(posedge CLK);
            #2;
            tb_c2_oe = 1'b1; tb_c2 = 2'b11;
            tb_a2_oe = 1'b1; tb_a2 = 15'h0002;
            tb_d2_oe = 1'b1; tb_d2 = 16'hDEAD;
            for (int i = 1; i < BEATS; i++) begin
               @(posedge CLK);
               #2;
               tb_c2 = 2'b00;
               tb_d2 = 16'hDEAD ^ 16'(i);
            end
            @(posedge CLK);
            #2;
            release_all();
         end
      join
      do_read("busy chk", 15'h0002, MEM_DELAY + BEATS + 1);

      // Reset in the middle of a read burst.
      issue(2'b10, 15'h1234, 16'h0000);
      #2;
      release_all();
      watch("rst rd pre", 15'h1234, 2, MEM_DELAY + 4);
      RESET_N = 1'b0;
      #1;
      check_value("rst rd c2", 32'(released({14'd0, c2_bus})), 32'd1);
      check_value("rst rd d2", 32'(released(d2_bus)), 32'd1);
      repeat (2) @(posedge CLK);
      #2 RESET_N = 1'b1;
      watch("rst rd quiet", 15'h0000, 0, 20);
      do_read("rst rd after", 15'h1234, MEM_DELAY + BEATS + 1);

      // Reset after two beats of a write: those beats stay, no response follows.
      wbeats[0] = 16'hAAAA;
      wbeats[1] = 16'hBBBB;
      model_write(15'h0003, 2);
      issue(2'b11, 15'h0003, 16'hAAAA);
      #2;
      tb_c2 = 2'b00;
      tb_d2 = 16'hBBBB;
      @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b0;
      #1;
      check_value("rst wr c2", 32'(released({14'd0, c2_bus})), 32'd1);
      release_all();
      repeat (2) @(posedge CLK);
      #2 RESET_N = 1'b1;
      watch("rst wr quiet", 15'h0000, 0, MEM_DELAY + 10);
      do_read("rst wr rd", 15'h0003, MEM_DELAY + BEATS + 1);

      // Idle noise: NOP, RESPONSE and Z on C2 must never provoke any drive.
      for (int c = 0; c < 200; c++) begin
         @(posedge CLK);
         #2;
         case ($urandom_range(0, 2))
            0:       begin tb_c2_oe = 1'b1; tb_c2 = 2'b00; end
            1:       begin tb_c2_oe = 1'b1; tb_c2 = 2'b01; end
            default: begin tb_c2_oe = 1'b0; end
         endcase
         tb_a2_oe = $urandom_range(0, 1) == 1;
         tb_a2    = 15'($urandom);
         tb_d2_oe = 1'b0;
         @(negedge CLK);
         check_value("noise d2", 32'(released(d2_bus)), 32'd1);
         if (!tb_c2_oe) check_value("noise c2", 32'(released({14'd0, c2_bus})), 32'd1);
         if (!tb_a2_oe) check_value("noise a2", 32'(released({1'b0, a2_bus})), 32'd1);
      end
      #2;
      release_all();

      // Random reads and writes over a small set of lines.
      for (int t = 0; t < 24; t++) begin
         logic [ADDR2_W-1:0] line;
         line = 15'h0100 + 15'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < BEATS; i++) wbeats[i] = 16'($urandom);
            do_write("rnd wr", line, MEM_DELAY + 1);
         end else begin
            do_read("rnd rd", line, MEM_DELAY + BEATS);
         end
         repeat ($urandom_range(0, 3)) @(posedge CLK);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
